// File: rtl/ct_mmu_pkg.sv
// rtl/ct_mmu_pkg.sv - shared MMU package: iuTLB refill FSM encoding and geometry defaults
//
// Purpose: single home for MMU-wide constants and the iuTLB refill state type,
//          imported by the refill controller and its victim selector.
// Contents: IUTLB_ENTRY_NUM, MMU_VPN_WIDTH, iutlb_refill_state_e.
package ct_mmu_pkg;

    localparam int IUTLB_ENTRY_NUM = 8;
    localparam int MMU_VPN_WIDTH   = 27;

    typedef enum logic [2:0] {
        REFILL_IDLE  = 3'd0,
        REFILL_REQ   = 3'd1,
        REFILL_WAIT  = 3'd2,
        REFILL_UPD   = 3'd3,
        REFILL_DRAIN = 3'd4
    } iutlb_refill_state_e;

endpackage

// File: rtl/ct_mmu_iutlb_victim_sel.sv
// rtl/ct_mmu_iutlb_victim_sel.sv - combinational iuTLB victim selector
//
// Purpose: picks the entry to overwrite on a refill. The lowest-index invalid
//          entry wins; when every entry is valid the round-robin pointer is used.
// Ports:
//   entry_vld_vec  in   per-entry valid bits
//   rr_ptr         in   round-robin pointer (register lives in the parent)
//   victim_vec     out  one-hot victim entry
//   use_ptr        out  victim came from the pointer, parent should advance it
module ct_mmu_iutlb_victim_sel
    import ct_mmu_pkg::*;
#(
    parameter int ENTRY_NUM = IUTLB_ENTRY_NUM,
    parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
    input  logic [ENTRY_NUM-1:0] entry_vld_vec,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [ENTRY_NUM-1:0] victim_vec,
    output logic                 use_ptr
);

    logic found;

    always_comb begin
        victim_vec = '0;
        found      = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!entry_vld_vec[i] && !found) begin
                victim_vec[i] = 1'b1;
                found         = 1'b1;
            end
        end
        if (!found) begin
            victim_vec[rr_ptr] = 1'b1;
        end
        use_ptr = !found;
    end

endmodule

// File: rtl/ct_mmu_iutlb_refill_ctrl.sv
// rtl/ct_mmu_iutlb_refill_ctrl.sv - iuTLB miss detection and jTLB refill sequencing
//
// Purpose: detects instruction-fetch iuTLB misses, requests a refill from the
//          jTLB, and writes the returned translation into one victim entry.
// Ports:
//   utlb_clk, cpurst                       clock, synchronous active-high reset
//   ifu_req_vld, ifu_req_vpn               fetch lookup
//   utlb_entry_vld_vec, utlb_entry_hit_vec per-entry valid / hit
//   utlb_clr                               flush, highest priority
//   jtlb_req_grant, jtlb_rsp_vld,
//   jtlb_rsp_fault                         jTLB handshake
//   utlb_hit                               combinational lookup hit
//   refill_req_vld, refill_req_vpn         refill request to jTLB
//   utlb_entry_upd_vec                     one-hot entry write enable
//   utlb_refill_busy                       requester must stall
//   utlb_refill_fault                      one-cycle page-fault pulse
module ct_mmu_iutlb_refill_ctrl
    import ct_mmu_pkg::*;
#(
    parameter int ENTRY_NUM = IUTLB_ENTRY_NUM,
    parameter int VPN_WIDTH = MMU_VPN_WIDTH
) (
    input  logic                 utlb_clk,
    input  logic                 cpurst,
    input  logic                 ifu_req_vld,
    input  logic [VPN_WIDTH-1:0] ifu_req_vpn,
    input  logic [ENTRY_NUM-1:0] utlb_entry_vld_vec,
    input  logic [ENTRY_NUM-1:0] utlb_entry_hit_vec,
    input  logic                 utlb_clr,
    input  logic                 jtlb_req_grant,
    input  logic                 jtlb_rsp_vld,
    input  logic                 jtlb_rsp_fault,
    output logic                 utlb_hit,
    output logic                 refill_req_vld,
    output logic [VPN_WIDTH-1:0] refill_req_vpn,
    output logic [ENTRY_NUM-1:0] utlb_entry_upd_vec,
    output logic                 utlb_refill_busy,
    output logic                 utlb_refill_fault
);

    localparam int PTR_W = $clog2(ENTRY_NUM);

    iutlb_refill_state_e state, state_nxt;

    logic [PTR_W-1:0]     rr_ptr;
    logic [VPN_WIDTH-1:0] vpn_q;
    logic                 fault_q;
    logic                 fault_nxt;
    logic                 miss;
    logic                 upd_fire;
    logic [ENTRY_NUM-1:0] victim_vec;
    logic                 victim_use_ptr;

    assign utlb_hit = ifu_req_vld & (|(utlb_entry_vld_vec & utlb_entry_hit_vec));
    assign miss     = ifu_req_vld & ~utlb_hit;

    ct_mmu_iutlb_victim_sel #(
        .ENTRY_NUM (ENTRY_NUM),
        .PTR_W     (PTR_W)
    ) u_victim_sel (
        .entry_vld_vec (utlb_entry_vld_vec),
        .rr_ptr        (rr_ptr),
        .victim_vec    (victim_vec),
        .use_ptr       (victim_use_ptr)
    );

    // A flush landing on the UPD cycle cancels the write outright.
    assign upd_fire = (state == REFILL_UPD) && !utlb_clr;

    always_comb begin
        state_nxt = state;
        fault_nxt = 1'b0;
        case (state)
            REFILL_IDLE: begin
                if (!utlb_clr && miss) begin
                    state_nxt = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                if (utlb_clr) begin
                    state_nxt = REFILL_IDLE;
                end else if (jtlb_req_grant) begin
                    state_nxt = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (utlb_clr) begin
                    // The jTLB still owes a response; swallow it in DRAIN
                    // unless it is arriving right now.
                    state_nxt = jtlb_rsp_vld ? REFILL_IDLE : REFILL_DRAIN;
                end else if (jtlb_rsp_vld) begin
                    state_nxt = jtlb_rsp_fault ? REFILL_IDLE : REFILL_UPD;
                    fault_nxt = jtlb_rsp_fault;
                end
            end
            REFILL_UPD: begin
                state_nxt = REFILL_IDLE;
            end
            REFILL_DRAIN: begin
                if (jtlb_rsp_vld) begin
                    state_nxt = REFILL_IDLE;
                end
            end
            default: begin
                state_nxt = REFILL_IDLE;
            end
        endcase
    end

    always_ff @(posedge utlb_clk) begin
        if (cpurst) begin
            state   <= REFILL_IDLE;
            rr_ptr  <= '0;
            vpn_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            fault_q <= fault_nxt;
            if (state == REFILL_IDLE && !utlb_clr && miss) begin
                vpn_q <= ifu_req_vpn;
            end
            if (upd_fire && victim_use_ptr) begin
                rr_ptr <= rr_ptr + PTR_W'(1);
            end
        end
    end

    assign refill_req_vld     = (state == REFILL_REQ);
    assign refill_req_vpn     = vpn_q;
    assign utlb_entry_upd_vec = upd_fire ? victim_vec : '0;
    assign utlb_refill_busy   = (state != REFILL_IDLE);
    assign utlb_refill_fault  = fault_q;

endmodule

// File: tb/tb_ct_mmu_iutlb_refill_ctrl.sv
// tb/tb_ct_mmu_iutlb_refill_ctrl.sv - self-checking bench for ct_mmu_iutlb_refill_ctrl
module tb_ct_mmu_iutlb_refill_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        ifu_req_vld;
    logic [26:0] ifu_req_vpn;
    logic [7:0]  vld_vec;
    logic [7:0]  hit_vec;
    logic        utlb_clr;
    logic        jtlb_req_grant;
    logic        jtlb_rsp_vld;
    logic        jtlb_rsp_fault;
    logic        utlb_hit;
    logic        refill_req_vld;
    logic [26:0] refill_req_vpn;
    logic [7:0]  upd_vec;
    logic        busy;
    logic        flt;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [2:0] m_ptr = 3'd0;

    always #5 clk = ~clk;

    ct_mmu_iutlb_refill_ctrl #(.ENTRY_NUM(8), .VPN_WIDTH(27)) dut (
        .utlb_clk           (clk),
        .cpurst             (cpurst),
        .ifu_req_vld        (ifu_req_vld),
        .ifu_req_vpn        (ifu_req_vpn),
        .utlb_entry_vld_vec (vld_vec),
        .utlb_entry_hit_vec (hit_vec),
        .utlb_clr           (utlb_clr),
        .jtlb_req_grant     (jtlb_req_grant),
        .jtlb_rsp_vld       (jtlb_rsp_vld),
        .jtlb_rsp_fault     (jtlb_rsp_fault),
        .utlb_hit           (utlb_hit),
        .refill_req_vld     (refill_req_vld),
        .refill_req_vpn     (refill_req_vpn),
        .utlb_entry_upd_vec (upd_vec),
        .utlb_refill_busy   (busy),
        .utlb_refill_fault  (flt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] lowest_zero(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) return 8'(1) << i;
        end
        return 8'h00;
    endfunction

    // Every entry write is matched against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (!cpurst && upd_vec != 8'h00) begin
            if (exp_q.size() == 0) check("upd_unexpected", upd_vec, 8'h00);
            else check("sb_upd_vec", upd_vec, exp_q.pop_front());
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        ifu_req_vld    = 1'b0;
        utlb_clr       = 1'b0;
        jtlb_req_grant = 1'b0;
        jtlb_rsp_vld   = 1'b0;
        jtlb_rsp_fault = 1'b0;
    endtask

    // Miss, grant next cycle, response two cycles after grant.
    task automatic run_refill(input logic [7:0] vld, input logic [26:0] vpn, input logic fault);
        logic [7:0] exp;
        vld_vec = vld;
        hit_vec = 8'h00;
        exp = (vld == 8'hFF) ? (8'(1) << m_ptr) : lowest_zero(vld);
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = vpn; #1;
        check("miss_hit", utlb_hit, 1'b0);
        check("miss_busy", busy, 1'b0);
        if (!fault) begin
            exp_q.push_back(exp);
            if (vld == 8'hFF) m_ptr = m_ptr + 3'd1;
        end
        next_cyc(); jtlb_req_grant = 1'b1; ifu_req_vld = 1'b1; ifu_req_vpn = ~vpn; #1;
        check("req_vld", refill_req_vld, 1'b1);
        check("req_vpn", refill_req_vpn, vpn);
        next_cyc(); #1;
        check("req_drop", refill_req_vld, 1'b0);
        check("vpn_stable", refill_req_vpn, vpn);
        next_cyc(); jtlb_rsp_vld = 1'b1; jtlb_rsp_fault = fault; #1;
        check("rsp_flt_early", flt, 1'b0);
        next_cyc(); #1;
        if (fault) begin
            check("flt_pulse", flt, 1'b1);
            check("flt_no_upd", upd_vec, 8'h00);
            check("flt_busy", busy, 1'b0);
        end else begin
            check("upd_vec", upd_vec, exp);
            check("upd_busy", busy, 1'b1);
            check("upd_no_flt", flt, 1'b0);
        end
        next_cyc(); #1;
        check("end_flt", flt, 1'b0);
        check("end_busy", busy, 1'b0);
        check("end_upd", upd_vec, 8'h00);
    endtask

    initial begin
        cpurst = 1'b1; ifu_req_vld = 1'b0; ifu_req_vpn = '0; vld_vec = 8'h00; hit_vec = 8'h00;
        utlb_clr = 1'b0; jtlb_req_grant = 1'b0; jtlb_rsp_vld = 1'b0; jtlb_rsp_fault = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_req_vld", refill_req_vld, 1'b0);
        check("rst_req_vpn", refill_req_vpn, 27'd0);
        check("rst_upd", upd_vec, 8'h00);
        check("rst_flt", flt, 1'b0);
        cpurst = 1'b0;

        // Cycle-numbered refill: miss c1, grant c2, rsp c5, write c6, idle c7.
        vld_vec = 8'h00;
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h1234; #1;
        check("c1_hit", utlb_hit, 1'b0);
        exp_q.push_back(8'h01);
        next_cyc(); jtlb_req_grant = 1'b1; #1;
        check("c2_req_vld", refill_req_vld, 1'b1);
        check("c2_req_vpn", refill_req_vpn, 27'h1234);
        next_cyc(); #1;
        check("c3_req_vld", refill_req_vld, 1'b0);
        next_cyc(); #1;
        check("c4_upd", upd_vec, 8'h00);
        next_cyc(); jtlb_rsp_vld = 1'b1; #1;
        check("c5_upd", upd_vec, 8'h00);
        next_cyc(); #1;
        check("c6_upd", upd_vec, 8'h01);
        check("c6_busy", busy, 1'b1);
        next_cyc(); #1;
        check("c7_busy", busy, 1'b0);

        // Lowest-invalid victim with a hole in the middle.
        run_refill(8'hF3, 27'h0ABCD, 1'b0);

        // Round-robin walk 0..7, then wrap back to entry 0.
        for (int i = 0; i < 9; i++) run_refill(8'hFF, 27'(32'h100 + i), 1'b0);

        // Fault: no write, pointer unchanged for the following refill.
        run_refill(8'hFF, 27'h3FFFF, 1'b1);
        run_refill(8'hFF, 27'h22222, 1'b0);

        // Flush in WAIT, response three cycles later drains.
        vld_vec = 8'hFF;
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h5555;
        next_cyc(); jtlb_req_grant = 1'b1;
        next_cyc(); utlb_clr = 1'b1; #1;
        check("drain_wait_busy", busy, 1'b1);
        next_cyc(); #1;
        check("drain_busy1", busy, 1'b1);
        next_cyc();
        next_cyc(); jtlb_rsp_vld = 1'b1; #1;
        check("drain_rsp_busy", busy, 1'b1);
        next_cyc(); #1;
        check("drain_done_busy", busy, 1'b0);
        check("drain_upd", upd_vec, 8'h00);
        check("drain_flt", flt, 1'b0);

        // Flush on the UPD cycle: write suppressed, pointer stays.
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h6666;
        next_cyc(); jtlb_req_grant = 1'b1;
        next_cyc(); jtlb_rsp_vld = 1'b1;
        next_cyc(); utlb_clr = 1'b1; #1;
        check("clr_upd_vec", upd_vec, 8'h00);
        next_cyc(); #1;
        check("clr_upd_busy", busy, 1'b0);

        // Flush together with the response in WAIT.
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h7777;
        next_cyc(); jtlb_req_grant = 1'b1;
        next_cyc(); jtlb_rsp_vld = 1'b1; utlb_clr = 1'b1;
        next_cyc(); #1;
        check("clr_rsp_busy", busy, 1'b0);
        check("clr_rsp_upd", upd_vec, 8'h00);
        check("clr_rsp_flt", flt, 1'b0);

        // Flush in REQ drops the request.
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h0888;
        next_cyc(); utlb_clr = 1'b1; #1;
        check("clr_req_vld_before", refill_req_vld, 1'b1);
        next_cyc(); #1;
        check("clr_req_vld", refill_req_vld, 1'b0);
        check("clr_req_busy", busy, 1'b0);

        // Pointer untouched by the aborted refills above.
        run_refill(8'hFF, 27'h09999, 1'b0);

        // Miss coincident with flush in IDLE does not start a refill.
        vld_vec = 8'h00; hit_vec = 8'h04;
        next_cyc(); ifu_req_vld = 1'b1; utlb_clr = 1'b1; #1;
        check("clr_miss_hit", utlb_hit, 1'b0);
        next_cyc(); #1;
        check("clr_miss_busy", busy, 1'b0);

        // Reset during REQ abandons the refill.
        vld_vec = 8'hFF; hit_vec = 8'h00;
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h0ABC;
        next_cyc(); cpurst = 1'b1; #1;
        check("pre_rst_req", refill_req_vld, 1'b1);
        next_cyc(); #1;
        check("mid_rst_req_vld", refill_req_vld, 1'b0);
        check("mid_rst_vpn", refill_req_vpn, 27'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_upd", upd_vec, 8'h00);
        check("mid_rst_flt", flt, 1'b0);
        cpurst = 1'b0;
        m_ptr = 3'd0;
        run_refill(8'hFF, 27'h0CDE, 1'b0);

        // Plain hit: no refill.
        vld_vec = 8'h04; hit_vec = 8'h04;
        next_cyc(); ifu_req_vld = 1'b1; ifu_req_vpn = 27'h4444; #1;
        check("hit", utlb_hit, 1'b1);
        next_cyc(); #1;
        check("hit_busy", busy, 1'b0);
        check("hit_req_vld", refill_req_vld, 1'b0);

        next_cyc(); #3;
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
